// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and grant helper for the RAM arbiter between the CPU control path
// and the serial program loader.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_ACK   = 2'd3;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;

    // CPU keeps priority unless the loader has been starved long enough.
    function automatic logic pick_ldr(input logic cpu_req, input logic ldr_req,
                                      input logic force_ldr);
        return ldr_req && (!cpu_req || force_ldr);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and RAM-side signal bundle for mem_bus_arbiter; slave is the arbiter's view,
// master is the view of the requesters and RAM macro around it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, ldr_ack, ldr_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );

endinterface

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Saturating count of consecutive contested CPU wins; forces the next contested grant
// to the loader once it reaches STARVE_MAX.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic contested,
    input  logic cpu_won,
    input  logic ldr_won,
    output logic force_ldr
);
    localparam logic [3:0] CntMax = 4'(STARVE_MAX);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ldr_won) begin
            cnt_d = 4'd0;
        end else if (cpu_won && contested && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_ldr = (cnt_q == CntMax);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter: CPU-priority grant with loader starvation guard, sequenced as
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK with every output registered.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus
);
    localparam logic [1:0] LastWait = 2'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic              acc_we_q, acc_we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;

    logic cpu_won, ldr_won, force_ldr, grant_ldr;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .contested (bus.cpu_req && bus.ldr_req),
        .cpu_won   (cpu_won),
        .ldr_won   (ldr_won),
        .force_ldr (force_ldr)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        acc_we_d    = acc_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        owner_d     = owner_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        cpu_won     = 1'b0;
        ldr_won     = 1'b0;
        grant_ldr   = pick_ldr(bus.cpu_req, bus.ldr_req, force_ldr);

        case (state_q)
            ARB_IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    ldr_won  = grant_ldr;
                    cpu_won  = !grant_ldr;
                    owner_d  = grant_ldr ? OWNER_LDR : OWNER_CPU;
                    acc_we_d = grant_ldr ? bus.ldr_we : bus.cpu_we;
                    addr_d   = grant_ldr ? bus.ldr_addr : bus.cpu_addr;
                    wdata_d  = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
                    mem_en_d = 1'b1;
                    mem_we_d = acc_we_d;
                    state_d  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                wait_d  = 2'd0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (wait_q == LastWait) begin
                    if (!acc_we_q) begin
                        if (owner_q == OWNER_LDR) ldr_rdata_d = bus.mem_rdata;
                        else                      cpu_rdata_d = bus.mem_rdata;
                    end
                    ldr_ack_d = (owner_q == OWNER_LDR);
                    cpu_ack_d = (owner_q == OWNER_CPU);
                    state_d   = ARB_ACK;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            wait_q      <= 2'd0;
            acc_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= OWNER_CPU;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            acc_we_q    <= acc_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.ldr_ack   = ldr_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each backed by a small RAM model that shows 0xFF whenever no read data is due.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst1, rst3;
    int   total = 0;
    int   bad   = 0;

    mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
    mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1));
    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(bus3));

    always #5 clk = ~clk;

    logic [7:0] ram1 [256];
    logic [7:0] ram3 [256];
    logic [7:0] rd1, p0, p1, p2;

    always @(posedge clk) begin
        if (rst1) ram1[8'h10] <= 8'hA5;
        else if (bus1.mem_en && bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
        rd1 <= (bus1.mem_en && !bus1.mem_we) ? ram1[bus1.mem_addr] : 8'hFF;
    end

    always @(posedge clk) begin
        if (rst3) ram3[8'h44] <= 8'h5A;
        else if (bus3.mem_en && bus3.mem_we) ram3[bus3.mem_addr] <= bus3.mem_wdata;
        p0 <= (bus3.mem_en && !bus3.mem_we) ? ram3[bus3.mem_addr] : 8'hFF;
        p1 <= p0;
        p2 <= p1;
    end

    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = p2;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
        bus1.ldr_req = 0; bus1.ldr_we = 0; bus1.ldr_addr = 0; bus1.ldr_wdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.ldr_req = 0; bus3.ldr_we = 0; bus3.ldr_addr = 0; bus3.ldr_wdata = 0;
        cyc(); cyc();
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.cpu_ack, bus1.ldr_ack, bus1.busy, bus1.owner}
            !== 6'b0) begin
            bad++; $display("FAIL reset_ctl1: got %b want 000000", {bus1.mem_en, bus1.mem_we,
                bus1.cpu_ack, bus1.ldr_ack, bus1.busy, bus1.owner});
        end
        total++;
        if ({bus1.mem_addr, bus1.mem_wdata, bus1.cpu_rdata, bus1.ldr_rdata} !== 32'h0) begin
            bad++; $display("FAIL reset_data1: got %h want 0", {bus1.mem_addr,
                bus1.mem_wdata, bus1.cpu_rdata, bus1.ldr_rdata});
        end
        total++;
        if (dut1.u_starve.cnt_q !== 4'd0) begin
            bad++; $display("FAIL reset_starve: got %0d want 0", dut1.u_starve.cnt_q);
        end
        total++;
        if ({bus3.mem_en, bus3.cpu_ack, bus3.busy, bus3.cpu_rdata} !== 11'h0) begin
            bad++; $display("FAIL reset_dut3: got %h want 0",
                {bus3.mem_en, bus3.cpu_ack, bus3.busy, bus3.cpu_rdata});
        end
        rst1 = 1'b0; rst3 = 1'b0;
        cyc();
    endtask

    task automatic test_cpu_read();
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h10;
        cyc();
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.busy} !== {2'b10, 8'h10, 1'b1}) begin
            bad++; $display("FAIL rd_issue: got en=%b we=%b addr=%h busy=%b want 1 0 10 1",
                bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.busy);
        end
        cyc();
        total++;
        if ({bus1.mem_en, bus1.cpu_ack, bus1.ldr_ack} !== 3'b000) begin
            bad++; $display("FAIL rd_wait: got en=%b ack=%b lack=%b want 0 0 0",
                bus1.mem_en, bus1.cpu_ack, bus1.ldr_ack);
        end
        cyc();
        total++;
        if ({bus1.cpu_ack, bus1.ldr_ack, bus1.cpu_rdata} !== {2'b10, 8'hA5}) begin
            bad++; $display("FAIL rd_ack: got ack=%b lack=%b rdata=%h want 1 0 a5",
                bus1.cpu_ack, bus1.ldr_ack, bus1.cpu_rdata);
        end
        bus1.cpu_req = 0;
        cyc();
        total++;
        if ({bus1.cpu_ack, bus1.busy, bus1.mem_en} !== 3'b000) begin
            bad++; $display("FAIL rd_done: got ack=%b busy=%b en=%b want 0 0 0",
                bus1.cpu_ack, bus1.busy, bus1.mem_en);
        end
    endtask

    task automatic test_ldr_write();
        bus1.ldr_req = 1; bus1.ldr_we = 1; bus1.ldr_addr = 8'h20; bus1.ldr_wdata = 8'h3C;
        cyc();
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.owner}
            !== {2'b11, 8'h20, 8'h3C, 1'b1}) begin
            bad++; $display("FAIL wr_issue: got en=%b we=%b a=%h d=%h own=%b want 1 1 20 3c 1",
                bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.owner);
        end
        cyc();
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.ldr_ack} !== 3'b000) begin
            bad++; $display("FAIL wr_wait: got en=%b we=%b lack=%b want 0 0 0",
                bus1.mem_en, bus1.mem_we, bus1.ldr_ack);
        end
        cyc();
        total++;
        if ({bus1.ldr_ack, bus1.cpu_ack, bus1.ldr_rdata, bus1.cpu_rdata}
            !== {2'b10, 8'h00, 8'hA5}) begin
            bad++; $display("FAIL wr_ack: got lack=%b ack=%b lrd=%h crd=%h want 1 0 00 a5",
                bus1.ldr_ack, bus1.cpu_ack, bus1.ldr_rdata, bus1.cpu_rdata);
        end
        bus1.ldr_req = 0; bus1.ldr_we = 0;
        cyc();
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h20;
        cyc(); cyc(); cyc();
        total++;
        if ({bus1.cpu_ack, bus1.cpu_rdata} !== {1'b1, 8'h3C}) begin
            bad++; $display("FAIL wr_readback: got ack=%b rdata=%h want 1 3c",
                bus1.cpu_ack, bus1.cpu_rdata);
        end
        bus1.cpu_req = 0;
        cyc();
    endtask

    task automatic test_contention();
        int order [5];
        int n = 0;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h10;
        bus1.ldr_req = 1; bus1.ldr_we = 0; bus1.ldr_addr = 8'h20;
        for (int i = 0; i < 60 && n < 5; i++) begin
            cyc();
            if (bus1.cpu_ack) begin
                order[n] = 0; n++;
            end
            if (bus1.ldr_ack && n < 5) begin
                order[n] = 1; n++;
                total++;
                if (dut1.u_starve.cnt_q !== 4'd0) begin
                    bad++; $display("FAIL starve_cleared: got %0d want 0", dut1.u_starve.cnt_q);
                end
                bus1.ldr_req = 0;
            end
        end
        bus1.cpu_req = 0; bus1.ldr_req = 0;
        total++;
        if (n != 5) begin
            bad++; $display("FAIL grant_count: got %0d want 5", n);
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (order[i] != ((i == 3) ? 1 : 0)) begin
                bad++; $display("FAIL grant_order[%0d]: got %0d want %0d", i, order[i],
                    (i == 3) ? 1 : 0);
            end
        end
        cyc();
    endtask

    task automatic test_lat3();
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 8'h44;
        cyc();
        total++;
        if ({bus3.mem_en, bus3.mem_addr} !== {1'b1, 8'h44}) begin
            bad++; $display("FAIL l3_issue: got en=%b addr=%h want 1 44",
                bus3.mem_en, bus3.mem_addr);
        end
        for (int c = 2; c <= 4; c++) begin
            cyc();
            total++;
            if ({bus3.mem_en, bus3.cpu_ack, bus3.cpu_rdata} !== 10'h0) begin
                bad++; $display("FAIL l3_wait%0d: got en=%b ack=%b rdata=%h want 0 0 00", c,
                    bus3.mem_en, bus3.cpu_ack, bus3.cpu_rdata);
            end
        end
        cyc();
        total++;
        if ({bus3.cpu_ack, bus3.cpu_rdata} !== {1'b1, 8'h5A}) begin
            bad++; $display("FAIL l3_ack: got ack=%b rdata=%h want 1 5a",
                bus3.cpu_ack, bus3.cpu_rdata);
        end
        bus3.cpu_req = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h10;
        cyc();
        bus1.ldr_req = 1; bus1.ldr_we = 0; bus1.ldr_addr = 8'h20;
        cyc();
        rst1 = 1'b1;
        cyc();
        total++;
        if ({bus1.mem_en, bus1.mem_we, bus1.cpu_ack, bus1.ldr_ack, bus1.busy, bus1.owner,
             bus1.mem_addr, bus1.mem_wdata, bus1.cpu_rdata, bus1.ldr_rdata} !== 38'h0) begin
            bad++; $display("FAIL rstmid_zero: got ack=%b busy=%b addr=%h crd=%h want all 0",
                bus1.cpu_ack, bus1.busy, bus1.mem_addr, bus1.cpu_rdata);
        end
        rst1 = 1'b0; bus1.cpu_req = 0;
        cyc();
        total++;
        if ({bus1.mem_en, bus1.owner, bus1.mem_addr, bus1.cpu_ack} !== {2'b11, 8'h20, 1'b0})
        begin
            bad++; $display("FAIL rstmid_grant: got en=%b own=%b addr=%h ack=%b want 1 1 20 0",
                bus1.mem_en, bus1.owner, bus1.mem_addr, bus1.cpu_ack);
        end
        cyc(); cyc();
        total++;
        if ({bus1.ldr_ack, bus1.cpu_ack, bus1.ldr_rdata} !== {2'b10, 8'h3C}) begin
            bad++; $display("FAIL rstmid_ldr_ack: got lack=%b ack=%b lrd=%h want 1 0 3c",
                bus1.ldr_ack, bus1.cpu_ack, bus1.ldr_rdata);
        end
        bus1.ldr_req = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 8'h10;
        bus1.ldr_req = 1; bus1.ldr_we = 0; bus1.ldr_addr = 8'h20;
        cyc();
        total++;
        if ({bus1.owner, bus1.mem_en, bus1.mem_addr, dut1.u_starve.cnt_q}
            !== {2'b01, 8'h10, 4'd1}) begin
            bad++; $display("FAIL b2b_cpu_grant: got own=%b en=%b addr=%h cnt=%0d want 0 1 10 1",
                bus1.owner, bus1.mem_en, bus1.mem_addr, dut1.u_starve.cnt_q);
        end
        cyc(); cyc();
        total++;
        if ({bus1.cpu_ack, bus1.cpu_rdata} !== {1'b1, 8'hA5}) begin
            bad++; $display("FAIL b2b_cpu_ack: got ack=%b rdata=%h want 1 a5",
                bus1.cpu_ack, bus1.cpu_rdata);
        end
        bus1.cpu_req = 0;
        cyc();
        total++;
        if ({bus1.busy, bus1.mem_en} !== 2'b00) begin
            bad++; $display("FAIL b2b_idle: got busy=%b en=%b want 0 0", bus1.busy, bus1.mem_en);
        end
        cyc();
        total++;
        if ({bus1.owner, bus1.mem_en, bus1.mem_addr} !== {2'b11, 8'h20}) begin
            bad++; $display("FAIL b2b_ldr_grant: got own=%b en=%b addr=%h want 1 1 20",
                bus1.owner, bus1.mem_en, bus1.mem_addr);
        end
        cyc(); cyc();
        total++;
        if ({bus1.ldr_ack, bus1.ldr_rdata, dut1.u_starve.cnt_q} !== {1'b1, 8'h3C, 4'd0}) begin
            bad++; $display("FAIL b2b_ldr_ack: got lack=%b lrd=%h cnt=%0d want 1 3c 0",
                bus1.ldr_ack, bus1.ldr_rdata, dut1.u_starve.cnt_q);
        end
        bus1.ldr_req = 0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_contention();
        test_lat3();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
